// File: rtl/fft_engine_arbiter.sv
// Round-robin arbiter that shares one FFT engine's start/done handshake among NREQ clients,
// with a RUN-state watchdog and a sticky flag for engine done pulses arriving out of turn.
module fft_engine_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_mode,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            eng_start,
  output logic            eng_mode,
  input  logic            eng_done,
  output logic [NREQ-1:0] req_done,
  output logic            timeout_err,
  output logic            spurious_err,
  output logic            busy
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] ID_LAST = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RUN     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t          state_reg;
  logic [IDW-1:0]  ptr_reg;
  logic [NREQ-1:0] gnt_reg;
  logic [IDW-1:0]  gnt_id_reg;
  logic            mode_reg;
  logic [CW-1:0]   cnt_reg;
  logic            ok_reg;
  logic            spurious_reg;

  logic            pick_valid;
  logic [IDW-1:0]  pick_idx;
  logic [IDW-1:0]  ptr_next;

  // Scan offsets from highest to lowest so the requester nearest ptr overrides the rest.
  always_comb begin : pick_logic
    int j;
    pick_valid = 1'b0;
    pick_idx   = '0;
    j          = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(ptr_reg) + i;
      if (j >= NREQ) j = j - NREQ;
      if (req[IDW'(j)]) begin
        pick_valid = 1'b1;
        pick_idx   = IDW'(j);
      end
    end
  end

  assign ptr_next = (gnt_id_reg == ID_LAST) ? '0 : gnt_id_reg + IDW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      ptr_reg      <= '0;
      gnt_reg      <= '0;
      gnt_id_reg   <= '0;
      mode_reg     <= 1'b0;
      cnt_reg      <= '0;
      ok_reg       <= 1'b0;
      spurious_reg <= 1'b0;
    end else begin
      if (eng_done && (state_reg != S_RUN)) spurious_reg <= 1'b1;

      case (state_reg)
        S_IDLE: begin
          if (pick_valid) begin
            gnt_reg    <= NREQ'(1) << pick_idx;
            gnt_id_reg <= pick_idx;
            mode_reg   <= req_mode[pick_idx];
            state_reg  <= S_GRANT;
          end
        end
        S_GRANT: begin
          cnt_reg   <= '0;
          state_reg <= S_RUN;
        end
        S_RUN: begin
          cnt_reg <= cnt_reg + CW'(1);
          // A done on the expiry cycle still counts as a successful completion.
          if (eng_done) begin
            ok_reg    <= 1'b1;
            state_reg <= S_RELEASE;
          end else if (cnt_reg == CNT_LAST) begin
            ok_reg    <= 1'b0;
            state_reg <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          ptr_reg   <= ptr_next;
          gnt_reg   <= '0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign gnt          = gnt_reg;
  assign gnt_id       = gnt_id_reg;
  assign eng_mode     = mode_reg;
  assign spurious_err = spurious_reg;
  assign eng_start    = (state_reg == S_GRANT);
  assign busy         = (state_reg != S_IDLE);
  assign timeout_err  = (state_reg == S_RELEASE) && !ok_reg;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_done
      assign req_done[gi] = (state_reg == S_RELEASE) && ok_reg && (gnt_id_reg == IDW'(gi));
    end
  endgenerate

  gnt_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  start_gnt_a:  assert property (@(posedge clk) disable iff (rst) eng_start |-> (gnt != '0));

endmodule

// File: tb/tb_fft_engine_arbiter.sv
// Directed bench for fft_engine_arbiter with a small behavioural engine that answers
// each start after a programmable latency, plus a hook to inject stray done pulses.
module tb_fft_engine_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, req_mode, gnt, req_done;
  logic [1:0] gnt_id;
  logic       eng_start, eng_mode, eng_done, timeout_err, spurious_err, busy;

  int checks = 0;
  int errors = 0;

  logic model_en;
  logic inj_done;
  int   eng_lat;
  int   cd;

  fft_engine_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_mode(req_mode), .gnt(gnt), .gnt_id(gnt_id),
    .eng_start(eng_start), .eng_mode(eng_mode), .eng_done(eng_done), .req_done(req_done),
    .timeout_err(timeout_err), .spurious_err(spurious_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Engine: start sampled at end of cycle s gives done in cycle s + eng_lat.
  always @(posedge clk) begin
    if (rst) cd <= 0;
    else if (model_en && eng_start) cd <= eng_lat;
    else if (cd > 0) cd <= cd - 1;
  end
  assign eng_done = (cd == 1) || inj_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_release(output logic found);
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (req_done != 4'b0 || timeout_err) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0; req_mode = 4'b0;
    model_en = 1'b1; eng_lat = 5; inj_done = 1'b0;
    tick(); tick();
    checks++;
    if ({gnt, gnt_id, eng_start, eng_mode, req_done, timeout_err, spurious_err, busy} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b id=%0d st=%b md=%b rd=%b to=%b sp=%b busy=%b exp all 0",
               gnt, gnt_id, eng_start, eng_mode, req_done, timeout_err, spurious_err, busy);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || gnt !== 4'b0) begin
      errors++; $display("FAIL reset_idle got busy=%b gnt=%b exp 0 0000", busy, gnt);
    end
    $display("txn reset done");
  endtask

  task automatic test_single();
    req = 4'b0001; req_mode = 4'b0001;
    tick();  // n+1
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0 || eng_start !== 1'b1 || eng_mode !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant got gnt=%b id=%0d st=%b md=%b busy=%b exp 0001 0 1 1 1",
               gnt, gnt_id, eng_start, eng_mode, busy);
    end
    for (int c = 2; c <= 6; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0001 || eng_start !== 1'b0 || req_done !== 4'b0 || eng_mode !== 1'b1) begin
        errors++;
        $display("FAIL single_run_n+%0d got gnt=%b st=%b rd=%b md=%b exp 0001 0 0000 1",
                 c, gnt, eng_start, req_done, eng_mode);
      end
    end
    tick();  // n+7
    checks++;
    if (req_done !== 4'b0001 || gnt !== 4'b0001 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL single_done got rd=%b gnt=%b to=%b exp 0001 0001 0", req_done, gnt, timeout_err);
    end
    req = 4'b0;
    tick();  // n+8
    checks++;
    if (busy !== 1'b0 || gnt !== 4'b0 || req_done !== 4'b0 || eng_mode !== 1'b1 || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL single_idle got busy=%b gnt=%b rd=%b md=%b id=%0d exp 0 0000 0000 1 0",
               busy, gnt, req_done, eng_mode, gnt_id);
    end
    $display("txn single requester 0 mode 1 complete");
  endtask

  task automatic test_round_robin();
    logic [3:0] modes;
    int starts;
    modes = 4'b1010;
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111; req_mode = modes;
    starts = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (eng_start) begin
        checks++;
        if (c !== 1 + 8 * starts || gnt_id !== 2'(starts % 4) || eng_mode !== modes[starts % 4]) begin
          errors++;
          $display("FAIL rr_start%0d got cycle=%0d id=%0d md=%b exp cycle=%0d id=%0d md=%b",
                   starts, c, gnt_id, eng_mode, 1 + 8 * starts, starts % 4, modes[starts % 4]);
        end
        $display("txn rr grant id=%0d at cycle n+%0d", gnt_id, c);
        starts++;
      end
    end
    req = 4'b0;
    checks++;
    if (starts !== 5) begin
      errors++; $display("FAIL rr_start_count got %0d exp 5", starts);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rr_idle got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_wrap();
    logic found;
    req = 4'b0010; req_mode = 4'b0;
    wait_release(found);
    checks++;
    if (!found || req_done !== 4'b0010) begin
      errors++; $display("FAIL wrap_serve1 got found=%b rd=%b exp 1 0010", found, req_done);
    end
    req = 4'b0; tick();
    req = 4'b0011;
    tick();
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      errors++; $display("FAIL wrap_first got gnt=%b id=%0d exp 0001 0", gnt, gnt_id);
    end
    wait_release(found);
    checks++;
    if (!found || req_done !== 4'b0001) begin
      errors++; $display("FAIL wrap_done0 got found=%b rd=%b exp 1 0001", found, req_done);
    end
    req = 4'b0010;
    tick(); tick();
    checks++;
    if (gnt !== 4'b0010 || eng_start !== 1'b1) begin
      errors++; $display("FAIL wrap_second got gnt=%b st=%b exp 0010 1", gnt, eng_start);
    end
    wait_release(found);
    checks++;
    if (!found || req_done !== 4'b0010) begin
      errors++; $display("FAIL wrap_done1 got found=%b rd=%b exp 1 0010", found, req_done);
    end
    req = 4'b0; tick();
    $display("txn wrap order 0 then 1 complete");
  endtask

  task automatic test_timeout();
    logic found;
    model_en = 1'b0;
    req = 4'b0100; req_mode = 4'b0;
    for (int c = 1; c <= 17; c++) begin
      tick();
      checks++;
      if (timeout_err !== 1'b0 || req_done !== 4'b0 || gnt !== 4'b0100) begin
        errors++;
        $display("FAIL timeout_wait_n+%0d got to=%b rd=%b gnt=%b exp 0 0000 0100", c, timeout_err, req_done, gnt);
      end
    end
    tick();  // n+18
    checks++;
    if (timeout_err !== 1'b1 || req_done !== 4'b0 || gnt !== 4'b0100) begin
      errors++;
      $display("FAIL timeout_pulse got to=%b rd=%b gnt=%b exp 1 0000 0100", timeout_err, req_done, gnt);
    end
    req = 4'b0;
    tick();  // n+19
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL timeout_clear got gnt=%b busy=%b to=%b exp 0000 0 0", gnt, busy, timeout_err);
    end
    $display("txn timeout requester 2 abandoned");
    model_en = 1'b1;
    req = 4'b1100;
    tick();
    checks++;
    if (gnt_id !== 2'd3 || gnt !== 4'b1000) begin
      errors++; $display("FAIL timeout_ptr got id=%0d gnt=%b exp 3 1000", gnt_id, gnt);
    end
    wait_release(found);
    checks++;
    if (!found || req_done !== 4'b1000) begin
      errors++; $display("FAIL timeout_next_done got found=%b rd=%b exp 1 1000", found, req_done);
    end
    req = 4'b0; tick();
  endtask

  task automatic test_expiry_and_spurious();
    eng_lat = 16;
    req = 4'b0001; req_mode = 4'b0;
    for (int c = 1; c <= 17; c++) tick();
    tick();  // n+18
    checks++;
    if (req_done !== 4'b0001 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL expiry_ok_wins got rd=%b to=%b exp 0001 0", req_done, timeout_err);
    end
    $display("txn expiry-cycle done accepted for requester 0");
    req = 4'b0; eng_lat = 5;
    tick();
    checks++;
    if (spurious_err !== 1'b0) begin
      errors++; $display("FAIL spurious_pre got %b exp 0", spurious_err);
    end
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    checks++;
    if (spurious_err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL spurious_set got sp=%b busy=%b exp 1 0", spurious_err, busy);
    end
    tick(); tick(); tick();
    checks++;
    if (spurious_err !== 1'b1) begin
      errors++; $display("FAIL spurious_sticky got %b exp 1", spurious_err);
    end
    $display("txn spurious done injected in idle");
  endtask

  task automatic test_rst_in_run();
    logic found;
    int stray;
    req = 4'b0010; req_mode = 4'b0010;
    tick(); tick();  // n+2: RUN
    rst = 1'b1;
    tick();
    checks++;
    if ({gnt, gnt_id, eng_start, eng_mode, req_done, timeout_err, spurious_err, busy} !== 16'h0) begin
      errors++;
      $display("FAIL rst_run_outputs got gnt=%b id=%0d st=%b md=%b rd=%b to=%b sp=%b busy=%b exp all 0",
               gnt, gnt_id, eng_start, eng_mode, req_done, timeout_err, spurious_err, busy);
    end
    rst = 1'b0; req = 4'b0;
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (req_done != 4'b0 || timeout_err || busy) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL rst_run_quiet got %0d active cycles exp 0", stray);
    end
    req = 4'b1001; req_mode = 4'b0;
    tick();
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      errors++; $display("FAIL rst_ptr_zero got gnt=%b id=%0d exp 0001 0", gnt, gnt_id);
    end
    wait_release(found);
    checks++;
    if (!found || req_done !== 4'b0001) begin
      errors++; $display("FAIL rst_first_done got found=%b rd=%b exp 1 0001", found, req_done);
    end
    req = 4'b0; tick();
    req = 4'b0100; req_mode = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100 || eng_start !== 1'b1 || eng_mode !== 1'b1) begin
      errors++; $display("FAIL rst_req2_grant got gnt=%b st=%b md=%b exp 0100 1 1", gnt, eng_start, eng_mode);
    end
    for (int c = 2; c <= 6; c++) tick();
    tick();  // n+7
    checks++;
    if (req_done !== 4'b0100) begin
      errors++; $display("FAIL rst_req2_done got rd=%b exp 0100", req_done);
    end
    req = 4'b0; tick();
    $display("txn reset in RUN then requester 2 served");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_expiry_and_spurious();
    test_rst_in_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
